cordic_cmd_sequencer: RTL and testbench
=======================================

Name: cordic_cmd_sequencer

Overview:
Host-side initiator for the CORDIC calculator top level. Accepts operation commands over a valid/ready channel and drives the calculator's operation/x/y/z/enable inputs. Waits for its done, captures the result and returns it over a valid/ready response channel. Sits between the bus/register front-end and the calculator. Owns sequencing, restart of the iterative core, error detection and timeout.

Parameters:
WIDTH, 32, data width of x/y/z/result (Q16.16 fixed point)
TIMEOUT_CYCLES, 64, max cycles in WAIT before an error response; must be > ITERATIONS+4
TAG_W, 4, width of command tag (used only with CORDIC_SEQ_TAG_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept command
cmd_op  in  4  operation code (calculator encoding: SIN=0, COS=1, MULT=7, DIV=8, SINH=9, COSH=10)
cmd_x  in  WIDTH  x operand, signed
cmd_y  in  WIDTH  y operand, signed
cmd_z  in  WIDTH  z operand, signed
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_data  out  WIDTH  signed result
resp_err  out  1  1 = unsupported op, divide-by-zero or timeout; resp_data=0
calc_enable  out  1  enable to calculator
calc_operation  out  4  op to calculator
calc_x  out  WIDTH  operand to calculator
calc_y  out  WIDTH  operand to calculator
calc_z  out  WIDTH  operand to calculator
calc_result  in  WIDTH  calculator result
calc_done  in  1  calculator done (level, combinational from core valid)

Behaviour:
- Single clock; reset synchronous active-high. Reset values: cmd_ready=0 during rst, 1 the cycle after; resp_valid=0, resp_data=0, resp_err=0, calc_enable=0, calc_operation=4'b1111, calc_x/y/z=0.
- FSM states: IDLE, CHECK, RUN, CLEAR, RESP.
- IDLE: cmd_ready=1. Handshake cmd_valid&cmd_ready latches op/x/y/z into operand registers and moves to CHECK. calc_* are driven only from these registers.
- CHECK (1 cycle): op not in {0,1,7,8,9,10}, or op==DIV with cmd_x==0 -> load resp_err=1, resp_data=0, go RESP; calc_enable never asserted. Otherwise -> RUN.
- RUN: calc_enable=1 held continuously. Watchdog counts from 0 on RUN entry.
  - First cycle with calc_done=1: capture calc_result into resp_data, resp_err=0, go CLEAR.
  - Watchdog reaching TIMEOUT_CYCLES-1 without done: resp_err=1, resp_data=0, go CLEAR.
  - Done and timeout in the same cycle: done wins.
- CLEAR (1 cycle): calc_enable=0, restarting the core for the next op; -> RESP.
- RESP: resp_valid=1; resp_data/resp_err held stable until resp_ready. Handshake -> IDLE. cmd_ready=0 in every state except IDLE; one command in flight.
- Latency (resp_valid rise from cmd accept): error path 2 cycles; normal path 3 + calculator cycles to done.
- rst in any state returns to IDLE with reset values; in-flight command is discarded, no response.
- No arithmetic on data; operands and result pass through bit-exact.

Optional Feature:
CORDIC_SEQ_TAG_EN
- Defined: ports cmd_tag (in, TAG_W) and resp_tag (out, TAG_W) exist. Tag is latched with the command and returned unchanged with its response; resp_tag resets to 0.
- Undefined: no tag ports and no tag register; behaviour is otherwise identical.

Decomposition:
- Shared package cordic_pkg:
  - op-code localparams (SIN..DEFAULT)
  - coordinate/mode codes
  - Q16.16 constants (K_INV_CIRCULAR=39797, K_INV_HYPERBOLIC=79134)
  - sequencer state encoding
  - op_supported function
- One sub-module: cordic_seq_watchdog. Inputs: clk, rst, clear, run. Output: expired. Up-counter with $clog2(TIMEOUT_CYCLES) bits; saturates, does not wrap.

Test Plan:
- MULT: x=0x00020000 (2.0), z=0x00018000 (1.5) -> one response, resp_err=0, resp_data=0x00030000 ±4 LSB. calc_enable high from RUN until done, then low exactly 1 cycle.
- DIV: y=0x00010000, x=0x00020000 -> resp_data=0x00008000 ±4 LSB. DIV with x=0 -> resp_err=1, resp_data=0, 2 cycles after accept, calc_enable never 1.
- op=4'b0100 (unsupported) -> resp_err=1 within 2 cycles, calc_operation/calc_enable untouched.
- Calculator stub holding calc_done=0 -> resp_err=1 after TIMEOUT_CYCLES in RUN; next command then completes normally.
- resp_ready low 10 cycles after a SIN z=0 result -> resp_valid, resp_data stable; cmd_ready=0 throughout; back-to-back second command accepted the cycle after the handshake.
- rst pulse mid-RUN -> next cycle calc_enable=0, resp_valid=0, cmd_ready=1; no stale response appears. With CORDIC_SEQ_TAG_EN: tag 0xA returned on resp_tag.

Source files
------------

// File: rtl/cordic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cordic_pkg
// Description : Shared definitions for the CORDIC calculator and its host-side
//               command sequencer: op codes, coordinate/mode codes, Q16.16
//               gain constants, sequencer state encoding and op filter.
// Revision    : 1.0 - initial release
// ============================================================================
package cordic_pkg;

  // Calculator operation codes
  localparam logic [3:0] c_OP_SIN     = 4'd0;
  localparam logic [3:0] c_OP_COS     = 4'd1;
  localparam logic [3:0] c_OP_MULT    = 4'd7;
  localparam logic [3:0] c_OP_DIV     = 4'd8;
  localparam logic [3:0] c_OP_SINH    = 4'd9;
  localparam logic [3:0] c_OP_COSH    = 4'd10;
  localparam logic [3:0] c_OP_DEFAULT = 4'b1111;

  // Coordinate system and iteration mode codes
  localparam logic [1:0] c_COORD_LINEAR     = 2'b00;
  localparam logic [1:0] c_COORD_CIRCULAR   = 2'b01;
  localparam logic [1:0] c_COORD_HYPERBOLIC = 2'b11;
  localparam logic       c_MODE_ROTATION    = 1'b0;
  localparam logic       c_MODE_VECTORING   = 1'b1;

  // Inverse CORDIC gains in Q16.16
  localparam logic signed [31:0] c_K_INV_CIRCULAR   = 32'sd39797;
  localparam logic signed [31:0] c_K_INV_HYPERBOLIC = 32'sd79134;

  // Sequencer state encoding
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_RUN   = 3'd2,
    S_CLEAR = 3'd3,
    S_RESP  = 3'd4
  } seq_state_t;

  // True for the op codes the calculator actually implements
  function automatic logic op_supported(input logic [3:0] op);
    return (op == c_OP_SIN)  || (op == c_OP_COS)  || (op == c_OP_MULT) ||
           (op == c_OP_DIV)  || (op == c_OP_SINH) || (op == c_OP_COSH);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cordic_seq_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : cordic_seq_watchdog
// Description : Saturating cycle counter used to bound how long the sequencer
//               waits for the calculator. expired rises once TIMEOUT_CYCLES-1
//               run cycles have been counted since the last clear.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_seq_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int                 c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_count;
  logic               w_expired;

  assign w_expired = (r_count == c_LAST);
  assign expired   = w_expired;

  // Count run cycles from zero after each clear; hold at the last value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (run && !w_expired) begin
      r_count <= r_count + c_CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/cordic_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cordic_cmd_sequencer
// Description : Host-side initiator for the CORDIC calculator. Accepts one
//               command at a time, filters unsupported ops and divide-by-zero,
//               runs the calculator with a watchdog, pulses enable low for one
//               cycle to restart the core, and returns the result.
//               Optional macro CORDIC_SEQ_TAG_EN adds cmd_tag/resp_tag ports.
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_cmd_sequencer
  import cordic_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_x,
  input  logic [WIDTH-1:0] cmd_y,
  input  logic [WIDTH-1:0] cmd_z,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_err,
  output logic             calc_enable,
  output logic [3:0]       calc_operation,
  output logic [WIDTH-1:0] calc_x,
  output logic [WIDTH-1:0] calc_y,
  output logic [WIDTH-1:0] calc_z,
  input  logic [WIDTH-1:0] calc_result,
  input  logic             calc_done
`ifdef CORDIC_SEQ_TAG_EN
  ,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [TAG_W-1:0] resp_tag
`endif
);

  seq_state_t       r_state;
  logic             r_cmd_ready;
  logic             r_resp_valid;
  logic             r_resp_err;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_calc_enable;
  logic [3:0]       r_calc_op;
  logic [WIDTH-1:0] r_calc_x;
  logic [WIDTH-1:0] r_calc_y;
  logic [WIDTH-1:0] r_calc_z;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_z;
  logic             w_cmd_accept;
  logic             w_reject;
  logic             w_expired;
  logic             w_wd_run;
  logic             w_wd_clear;

  // Ready is masked while rst is high so nothing is accepted during reset.
  assign cmd_ready      = r_cmd_ready & ~rst;
  assign resp_valid     = r_resp_valid;
  assign resp_data      = r_resp_data;
  assign resp_err       = r_resp_err;
  assign calc_enable    = r_calc_enable;
  assign calc_operation = r_calc_op;
  assign calc_x         = r_calc_x;
  assign calc_y         = r_calc_y;
  assign calc_z         = r_calc_z;

  assign w_cmd_accept = cmd_valid && r_cmd_ready;
  assign w_reject     = !op_supported(r_op) || ((r_op == c_OP_DIV) && (r_x == '0));
  assign w_wd_run     = (r_state == S_RUN);
  assign w_wd_clear   = (r_state != S_RUN);

  cordic_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_wd_clear),
    .run     (w_wd_run),
    .expired (w_expired)
  );

  // Command sequencing FSM; every output is registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cmd_ready   <= 1'b1;
      r_resp_valid  <= 1'b0;
      r_resp_err    <= 1'b0;
      r_resp_data   <= '0;
      r_calc_enable <= 1'b0;
      r_calc_op     <= c_OP_DEFAULT;
      r_calc_x      <= '0;
      r_calc_y      <= '0;
      r_calc_z      <= '0;
      r_op          <= c_OP_DEFAULT;
      r_x           <= '0;
      r_y           <= '0;
      r_z           <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cmd_accept) begin
            r_op        <= cmd_op;
            r_x         <= cmd_x;
            r_y         <= cmd_y;
            r_z         <= cmd_z;
            r_cmd_ready <= 1'b0;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_reject) begin
            // Rejected commands never touch the calculator interface.
            r_resp_err   <= 1'b1;
            r_resp_data  <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_calc_op     <= r_op;
            r_calc_x      <= r_x;
            r_calc_y      <= r_y;
            r_calc_z      <= r_z;
            r_calc_enable <= 1'b1;
            r_state       <= S_RUN;
          end
        end
        S_RUN: begin
          // A done seen on the expiry cycle still counts as success.
          if (calc_done) begin
            r_resp_data   <= calc_result;
            r_resp_err    <= 1'b0;
            r_calc_enable <= 1'b0;
            r_state       <= S_CLEAR;
          end else if (w_expired) begin
            r_resp_data   <= '0;
            r_resp_err    <= 1'b1;
            r_calc_enable <= 1'b0;
            r_state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_resp_valid <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CORDIC_SEQ_TAG_EN
  logic [TAG_W-1:0] r_tag;

  // The tag travels with its command and is returned with the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag <= '0;
    end else if (w_cmd_accept && (r_state == S_IDLE)) begin
      r_tag <= cmd_tag;
    end
  end

  assign resp_tag = r_tag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cordic_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_cmd_sequencer
// Description : Self-checking bench for cordic_cmd_sequencer. A calculator stub
//               with programmable latency answers the sequencer; a cycle-level
//               transaction model predicts every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_cmd_sequencer;

  localparam int W = 32;
  localparam int T = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [3:0]   cmd_op = 4'd0;
  logic [W-1:0] cmd_x = '0;
  logic [W-1:0] cmd_y = '0;
  logic [W-1:0] cmd_z = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [W-1:0] resp_data;
  logic         resp_err;
  logic         calc_enable;
  logic [3:0]   calc_operation;
  logic [W-1:0] calc_x;
  logic [W-1:0] calc_y;
  logic [W-1:0] calc_z;
  logic [W-1:0] calc_result;
  logic         calc_done;
`ifdef CORDIC_SEQ_TAG_EN
  logic [3:0]   cmd_tag = 4'd0;
  logic [3:0]   resp_tag;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  cordic_cmd_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(T), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err),
    .calc_enable(calc_enable), .calc_operation(calc_operation),
    .calc_x(calc_x), .calc_y(calc_y), .calc_z(calc_z),
    .calc_result(calc_result), .calc_done(calc_done)
`ifdef CORDIC_SEQ_TAG_EN
    , .cmd_tag(cmd_tag), .resp_tag(resp_tag)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Reference calculator: MULT/DIV are real Q16.16 arithmetic, the others are
  // simple deterministic functions of the operands.
  function automatic logic [31:0] calc_fn(input logic [3:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] z);
    longint p;
    case (op)
      4'd0:  calc_fn = z;
      4'd1:  calc_fn = 32'h0001_0000 - z;
      4'd7:  begin
        p = (longint'($signed(x)) * longint'($signed(z))) >>> 16;
        calc_fn = p[31:0];
      end
      4'd8:  begin
        if (x == 32'd0) calc_fn = 32'd0;
        else begin
          p = (longint'($signed(y)) * 64'sd65536) / longint'($signed(x));
          calc_fn = p[31:0];
        end
      end
      4'd9:  calc_fn = z ^ 32'h0000_5A5A;
      4'd10: calc_fn = x + 32'h0001_0000;
      default: calc_fn = 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic logic is_supported(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd10};
  endfunction

  // Calculator stub: done rises after stub_lat enabled cycles, stays while enabled.
  int stub_lat = 0;
  int en_cnt   = 0;
  always @(posedge clk) en_cnt <= calc_enable ? en_cnt + 1 : 0;
  assign calc_done   = calc_enable && (en_cnt >= stub_lat);
  assign calc_result = calc_fn(calc_operation, calc_x, calc_y, calc_z);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response-ready driver
  logic rr_force_low = 1'b0;
  logic rr_always    = 1'b1;
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rr_force_low)   resp_ready = 1'b0;
      else if (rr_always) resp_ready = 1'b1;
      else                resp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Transaction model state
  logic         m_busy = 1'b0;
  logic         m_has_run = 1'b0;
  int           m_en_start = 0, m_en_end = 0, m_resp_cyc = 0;
  logic [W-1:0] m_exp_data = '0;
  logic         m_exp_err = 1'b0;
  logic [3:0]   m_run_op = 4'hF, m_calc_op = 4'hF, m_tag = 4'h0;
  logic [W-1:0] m_run_x = '0, m_run_y = '0, m_run_z = '0;
  logic [W-1:0] m_calc_x = '0, m_calc_y = '0, m_calc_z = '0;

  // Compare process: predicts and checks all outputs each cycle.
  initial begin : compare
    logic e_valid, e_en;
    int   eff;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("cmd_ready_in_rst", {63'd0, cmd_ready}, 64'd0);
        m_busy = 1'b0; m_calc_op = 4'hF; m_calc_x = '0; m_calc_y = '0; m_calc_z = '0;
        m_tag = 4'h0;
      end else begin
        e_valid = m_busy && (cyc >= m_resp_cyc);
        e_en    = m_busy && m_has_run && (cyc >= m_en_start) && (cyc <= m_en_end);
        if (m_busy && m_has_run && (cyc == m_en_start)) begin
          m_calc_op = m_run_op; m_calc_x = m_run_x; m_calc_y = m_run_y; m_calc_z = m_run_z;
        end
        chk("cmd_ready",      {63'd0, cmd_ready},   {63'd0, !m_busy});
        chk("resp_valid",     {63'd0, resp_valid},  {63'd0, e_valid});
        chk("calc_enable",    {63'd0, calc_enable}, {63'd0, e_en});
        chk("calc_operation", {60'd0, calc_operation}, {60'd0, m_calc_op});
        chk("calc_xyz", {calc_x, calc_y ^ calc_z}, {m_calc_x, m_calc_y ^ m_calc_z});
        if (e_valid) begin
          chk("resp_data", {32'd0, resp_data}, {32'd0, m_exp_data});
          chk("resp_err",  {63'd0, resp_err},  {63'd0, m_exp_err});
`ifdef CORDIC_SEQ_TAG_EN
          chk("resp_tag", {60'd0, resp_tag}, {60'd0, m_tag});
`endif
        end
        if (!m_busy && cmd_valid) begin
          m_busy = 1'b1;
          m_run_op = cmd_op; m_run_x = cmd_x; m_run_y = cmd_y; m_run_z = cmd_z;
`ifdef CORDIC_SEQ_TAG_EN
          m_tag = cmd_tag;
`endif
          if (!is_supported(cmd_op) || (cmd_op == 4'd8 && cmd_x == '0)) begin
            m_has_run = 1'b0; m_resp_cyc = cyc + 2;
            m_exp_data = '0; m_exp_err = 1'b1;
          end else begin
            eff = (stub_lat < T) ? stub_lat : T - 1;
            m_has_run = 1'b1;
            m_en_start = cyc + 2; m_en_end = cyc + 2 + eff; m_resp_cyc = cyc + 4 + eff;
            if (stub_lat < T) begin
              m_exp_data = calc_fn(cmd_op, cmd_x, cmd_y, cmd_z); m_exp_err = 1'b0;
            end else begin
              m_exp_data = '0; m_exp_err = 1'b1;
            end
          end
        end else if (e_valid && resp_ready) begin
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] z, input int lat, input logic [3:0] tg,
                      output int acc);
    int n;
    @(posedge clk); #1;
    stub_lat = lat; cmd_op = op; cmd_x = x; cmd_y = y; cmd_z = z; cmd_valid = 1'b1;
`ifdef CORDIC_SEQ_TAG_EN
    cmd_tag = tg;
`endif
    n = 0;
    acc = -1;
    while (acc < 0) begin
      @(negedge clk);
      if (cmd_ready) acc = cyc;
      else begin
        n++;
        if (n > 300) begin
          chk("accept_timeout", 64'd0, 64'd1);
          acc = cyc;
        end
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(output logic [31:0] d, output logic e, output int first);
    int n;
    logic done;
    first = -1; done = 1'b0; n = 0; d = '0; e = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (resp_valid && first < 0) first = cyc;
      if (resp_valid && resp_ready) begin
        d = resp_data; e = resp_err; done = 1'b1;
      end else begin
        n++;
        if (n > 300) begin
          chk("resp_timeout", 64'd0, 64'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  initial begin : global_bound
    #800000;
    $display("FAIL global_time_limit: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : main
    int          acc, first, h, a;
    logic [31:0] d;
    logic        e;
    logic [3:0]  ops [6];
    logic [3:0]  op;
    logic [31:0] x;
    int          lat;
    ops = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd9, 4'd10};

    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready",   {63'd0, cmd_ready},   64'd1);
    chk("rst_resp_valid",  {63'd0, resp_valid},  64'd0);
    chk("rst_resp_data",   {32'd0, resp_data},   64'd0);
    chk("rst_resp_err",    {63'd0, resp_err},    64'd0);
    chk("rst_calc_enable", {63'd0, calc_enable}, 64'd0);
    chk("rst_calc_op",     {60'd0, calc_operation}, 64'hF);
    chk("rst_calc_x",      {32'd0, calc_x},      64'd0);

    // MULT 2.0 * 1.5 with a 5-cycle calculator
    send(4'd7, 32'h0002_0000, 32'h0, 32'h0001_8000, 5, 4'hA, acc);
    wait_resp(d, e, first);
    chk("mult_data", {32'd0, d}, 64'h0003_0000);
    chk("mult_err", {63'd0, e}, 64'd0);
    chk("mult_latency", 64'(first - acc), 64'd9);
`ifdef CORDIC_SEQ_TAG_EN
    chk("mult_tag", {60'd0, resp_tag}, 64'hA);
`endif

    // DIV 1.0 / 2.0
    send(4'd8, 32'h0002_0000, 32'h0001_0000, 32'h0, 7, 4'h3, acc);
    wait_resp(d, e, first);
    chk("div_data", {32'd0, d}, 64'h0000_8000);
    chk("div_latency", 64'(first - acc), 64'd11);

    // DIV by zero: error after 2 cycles, calculator untouched
    send(4'd8, 32'h0, 32'h0001_0000, 32'h0, 2, 4'h4, acc);
    wait_resp(d, e, first);
    chk("div0_err", {63'd0, e}, 64'd1);
    chk("div0_data", {32'd0, d}, 64'd0);
    chk("div0_latency", 64'(first - acc), 64'd2);

    // Unsupported op 4
    send(4'd4, 32'h1234_5678, 32'h1, 32'h2, 2, 4'h5, acc);
    wait_resp(d, e, first);
    chk("unsup_err", {63'd0, e}, 64'd1);
    chk("unsup_latency", 64'(first - acc), 64'd2);
    chk("unsup_calc_op", {60'd0, calc_operation}, 64'd8);
    chk("unsup_calc_enable", {63'd0, calc_enable}, 64'd0);

    // Calculator never answers: timeout, then a normal command recovers
    send(4'd1, 32'h0, 32'h0, 32'h0000_4000, 1000, 4'h6, acc);
    wait_resp(d, e, first);
    chk("timeout_err", {63'd0, e}, 64'd1);
    chk("timeout_data", {32'd0, d}, 64'd0);
    chk("timeout_latency", 64'(first - acc), 64'(T + 3));
    send(4'd7, 32'h0002_0000, 32'h0, 32'h0001_8000, 2, 4'h7, acc);
    wait_resp(d, e, first);
    chk("recover_data", {32'd0, d}, 64'h0003_0000);
    chk("recover_err", {63'd0, e}, 64'd0);

    // Hold resp_ready low 10 cycles on a SIN z=0 result, queue a second command
    rr_force_low = 1'b1;
    send(4'd0, 32'h0, 32'h0, 32'h0, 3, 4'h8, acc);
    h = 0;
    while (!resp_valid && h < 100) begin @(negedge clk); h++; end
    chk("hold_first_data", {32'd0, resp_data}, 64'd0);
    @(posedge clk); #1;
    stub_lat = 2; cmd_op = 4'd7; cmd_x = 32'h0002_0000; cmd_y = '0; cmd_z = 32'h0001_8000;
    cmd_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("hold_resp_valid", {63'd0, resp_valid}, 64'd1);
      chk("hold_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    end
    @(posedge clk); #1 rr_force_low = 1'b0;
    h = -1; a = -1;
    for (int n = 0; n < 50 && a < 0; n++) begin
      @(negedge clk);
      if (h < 0 && resp_valid && resp_ready) h = cyc;
      else if (h >= 0 && cmd_ready && cmd_valid) a = cyc;
    end
    chk("b2b_accept_gap", 64'(a - h), 64'd1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    wait_resp(d, e, first);
    chk("b2b_data", {32'd0, d}, 64'h0003_0000);

    // Reset pulse while the calculator is running
    send(4'd1, 32'h0, 32'h0, 32'h0000_1000, 50, 4'h9, acc);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_calc_enable", {63'd0, calc_enable}, 64'd0);
    chk("midrst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("midrst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    repeat (80) @(negedge clk);

    // Randomized traffic, including latencies around the timeout boundary
    rr_always = 1'b0;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 3) == 0) op = 4'($urandom_range(0, 15));
      else op = ops[$urandom_range(0, 5)];
      x = $urandom;
      if ($urandom_range(0, 5) == 0) x = '0;
      if ($urandom_range(0, 9) == 0) lat = $urandom_range(T - 3, T + 2);
      else lat = $urandom_range(0, 12);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(op, x, $urandom, $urandom, lat, 4'($urandom_range(0, 15)), acc);
      wait_resp(d, e, first);
    end
    rr_always = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
